// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: collective-control call scheduler for one car.
// The scheduler latches cab and hall calls, which also drive the button lamps.
// It runs a SCAN sweep: the car keeps going one way while calls lie ahead, then reverses.
// It tells the car which way to move, where to stop and when to open the door.
// A call is cleared while the car serves its floor.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   btn_in        cab floor buttons (level, OR-latched)
//   btn_up_out    hall up-call buttons (top floor bit ignored)
//   btn_down_out  hall down-call buttons (bottom floor bit ignored)
//   car_floor     current car floor
//   car_stopped   car halted and levelled at car_floor
//   door_done     one-cycle pulse: door cycle finished
//   dir           00 idle, 01 up, 10 down
//   stop_req      car must stop at car_floor
//   open_req      door open/hold request (high while serving)
//   target_floor  nearest pending floor in the current sweep direction
//   lamp_in, lamp_up, lamp_down  pending-call registers
module elevator_call_scheduler #(
  parameter int unsigned BUTTONS_WIDTH = 8,
  parameter int unsigned FLOOR_BITS    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  input  logic [FLOOR_BITS-1:0]    car_floor,
  input  logic                     car_stopped,
  input  logic                     door_done,
  output logic [1:0]               dir,
  output logic                     stop_req,
  output logic                     open_req,
  output logic [FLOOR_BITS-1:0]    target_floor,
  output logic [BUTTONS_WIDTH-1:0] lamp_in,
  output logic [BUTTONS_WIDTH-1:0] lamp_up,
  output logic [BUTTONS_WIDTH-1:0] lamp_down
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_SERVE} state_t;

  localparam logic [FLOOR_BITS-1:0]    TOP_FLOOR = FLOOR_BITS'(BUTTONS_WIDTH - 1);
  // There is no up call at the top floor and no down call at the bottom floor.
  localparam logic [BUTTONS_WIDTH-1:0] UP_MASK   = {1'b0, {(BUTTONS_WIDTH-1){1'b1}}};
  localparam logic [BUTTONS_WIDTH-1:0] DOWN_MASK = {{(BUTTONS_WIDTH-1){1'b1}}, 1'b0};

  state_t                  state, state_n;
  logic                    sweep_up, sweep_up_n;
  logic [BUTTONS_WIDTH-1:0] pend_in, pend_up, pend_down;
  logic [BUTTONS_WIDTH-1:0] pend_in_n, pend_up_n, pend_down_n;
  logic [BUTTONS_WIDTH-1:0] pend_all, above_mask, below_mask, here_hot;
  logic [BUTTONS_WIDTH-1:0] clr_in, clr_up, clr_down;
  logic                    above, below, here, in_f, up_f, down_f;
  logic                    stop_up, stop_down, up_found;
  logic [FLOOR_BITS-1:0]   up_tgt, down_tgt;
  logic [1:0]              dir_q, dir_n;
  logic                    stop_q, stop_n, open_q, open_n;
  logic [FLOOR_BITS-1:0]   tgt_q, tgt_n;

  // Floor-relative views of the pending calls.
  always_comb begin
    pend_all   = pend_in | pend_up | pend_down;
    above_mask = '0;
    below_mask = '0;
    here_hot   = '0;
    up_tgt     = car_floor;
    down_tgt   = car_floor;
    up_found   = 1'b0;
    for (int unsigned i = 0; i < BUTTONS_WIDTH; i++) begin
      above_mask[i] = FLOOR_BITS'(i) > car_floor;
      below_mask[i] = FLOOR_BITS'(i) < car_floor;
      here_hot[i]   = FLOOR_BITS'(i) == car_floor;
      // First hit scanning upward is the lowest call above the car.
      if (!up_found && pend_all[i] && above_mask[i]) begin
        up_tgt   = FLOOR_BITS'(i);
        up_found = 1'b1;
      end
      // Last hit scanning upward is the highest call below the car.
      if (pend_all[i] && below_mask[i]) down_tgt = FLOOR_BITS'(i);
    end
    above     = |(pend_all & above_mask);
    below     = |(pend_all & below_mask);
    here      = |(pend_all & here_hot);
    in_f      = |(pend_in & here_hot);
    up_f      = |(pend_up & here_hot);
    down_f    = |(pend_down & here_hot);
    // An opposite-direction hall call only stops the car at the end of its sweep.
    stop_up   = in_f | up_f | (down_f & !above);
    stop_down = in_f | down_f | (up_f & !below);
  end

  // Next state and registered-output values.
  always_comb begin
    state_n = state;
    clr_in  = '0;
    clr_up  = '0;
    clr_down = '0;
    unique case (state)
      S_IDLE: begin
        if (here && car_stopped) state_n = S_SERVE;
        else if (above)          state_n = S_UP;
        else if (below)          state_n = S_DOWN;
      end
      S_UP: begin
        if (car_stopped && stop_up) state_n = S_SERVE;
        else if (!above && !here)   state_n = below ? S_DOWN : S_IDLE;
      end
      S_DOWN: begin
        if (car_stopped && stop_down) state_n = S_SERVE;
        else if (!below && !here)     state_n = above ? S_UP : S_IDLE;
      end
      S_SERVE: begin
        clr_in = here_hot;
        if (sweep_up) begin
          clr_up   = here_hot;
          clr_down = above ? '0 : here_hot;
        end else begin
          clr_down = here_hot;
          clr_up   = below ? '0 : here_hot;
        end
        if (door_done) begin
          if (sweep_up) state_n = above ? S_UP : (below ? S_DOWN : S_IDLE);
          else          state_n = below ? S_DOWN : (above ? S_UP : S_IDLE);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Sweep memory follows whichever motion state is entered. Entering SERVE
    // from UP or DOWN therefore keeps the sweep that brought the car here.
    sweep_up_n = (state_n == S_UP) ? 1'b1 : ((state_n == S_DOWN) ? 1'b0 : sweep_up);

    // A clear takes priority over a press of the same bit in the same cycle.
    pend_in_n   = (pend_in   | btn_in)                   & ~clr_in;
    pend_up_n   = (pend_up   | (btn_up_out & UP_MASK))   & ~clr_up;
    pend_down_n = (pend_down | (btn_down_out & DOWN_MASK)) & ~clr_down;

    dir_n  = 2'b00;
    stop_n = 1'b0;
    open_n = 1'b0;
    tgt_n  = car_floor;
    unique case (state_n)
      S_UP: begin
        dir_n  = (car_floor != TOP_FLOOR) ? 2'b01 : 2'b00;
        stop_n = stop_up;
        tgt_n  = up_tgt;
      end
      S_DOWN: begin
        dir_n  = (car_floor != '0) ? 2'b10 : 2'b00;
        stop_n = stop_down;
        tgt_n  = down_tgt;
      end
      S_SERVE: begin
        stop_n = 1'b1;
        open_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sweep_up  <= 1'b1;
      pend_in   <= '0;
      pend_up   <= '0;
      pend_down <= '0;
      dir_q     <= 2'b00;
      stop_q    <= 1'b0;
      open_q    <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state     <= state_n;
      sweep_up  <= sweep_up_n;
      pend_in   <= pend_in_n;
      pend_up   <= pend_up_n;
      pend_down <= pend_down_n;
      dir_q     <= dir_n;
      stop_q    <= stop_n;
      open_q    <= open_n;
      tgt_q     <= tgt_n;
    end
  end

  assign dir          = dir_q;
  assign stop_req     = stop_q;
  assign open_req     = open_q;
  assign target_floor = tgt_q;
  assign lamp_in      = pend_in;
  assign lamp_up      = pend_up;
  assign lamp_down    = pend_down;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler.
// The stimulus process pushes hand-computed expectations tagged with a cycle number.
// A monitor process pops and compares them at the falling edge of that cycle.
module tb_elevator_call_scheduler;

  localparam int unsigned BW = 8;
  localparam int unsigned FB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] btn_in, btn_up_out, btn_down_out;
  logic [FB-1:0] car_floor;
  logic          car_stopped, door_done;
  logic [1:0]    dir;
  logic          stop_req, open_req;
  logic [FB-1:0] target_floor;
  logic [BW-1:0] lamp_in, lamp_up, lamp_down;

  elevator_call_scheduler #(.BUTTONS_WIDTH(BW), .FLOOR_BITS(FB)) dut (
    .clk(clk), .reset(reset),
    .btn_in(btn_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
    .car_floor(car_floor), .car_stopped(car_stopped), .door_done(door_done),
    .dir(dir), .stop_req(stop_req), .open_req(open_req),
    .target_floor(target_floor),
    .lamp_in(lamp_in), .lamp_up(lamp_up), .lamp_down(lamp_down)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_DIR, K_STOP, K_OPEN, K_TGT, K_LIN, K_LUP, K_LDN} kind_t;
  typedef struct {
    int unsigned due;
    kind_t       kind;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic expect_out(input kind_t k, input logic [31:0] v, input string nm);
    exp_t e;
    e.due  = cyc;
    e.kind = k;
    e.val  = v;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_t k);
    case (k)
      K_DIR:   return 32'(dir);
      K_STOP:  return 32'(stop_req);
      K_OPEN:  return 32'(open_req);
      K_TGT:   return 32'(target_floor);
      K_LIN:   return 32'(lamp_in);
      K_LUP:   return 32'(lamp_up);
      default: return 32'(lamp_down);
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  exp_t        mon_e;
  logic [31:0] mon_got;
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e   = sb.pop_front();
        mon_got = observe(mon_e.kind);
        total++;
        if (mon_e.due != cyc)
          $display("FAIL %s: not sampled in cycle %0d (now %0d)", mon_e.nm, mon_e.due, cyc);
        else if (mon_got === mon_e.val)
          passed++;
        else
          $display("FAIL %s: got %0h, expected %0h (cycle %0d)", mon_e.nm, mon_got, mon_e.val, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_out(K_DIR,  0, {tag, "_dir"});
    expect_out(K_STOP, 0, {tag, "_stop"});
    expect_out(K_OPEN, 0, {tag, "_open"});
    expect_out(K_TGT,  0, {tag, "_tgt"});
    expect_out(K_LIN,  0, {tag, "_lamp_in"});
    expect_out(K_LUP,  0, {tag, "_lamp_up"});
    expect_out(K_LDN,  0, {tag, "_lamp_down"});
  endtask

  initial begin
    reset        = 1'b0;
    btn_in       = '0;
    btn_up_out   = '0;
    btn_down_out = '0;
    car_floor    = '0;
    car_stopped  = 1'b1;
    door_done    = 1'b0;

    tick();                                   // cycle 1, still in reset
    expect_reset_state("reset");
    @(negedge clk); #1;
    reset = 1'b1;

    // Test 1: cab call to top floor, travel, serve, back to idle.
    btn_in = 8'h80;
    tick();                                   // c2: call latched
    btn_in = '0;
    expect_out(K_LIN, 32'h80, "t1_lamp_in7");
    expect_out(K_DIR, 0, "t1_dir_before_move");
    tick();                                   // c3: IDLE -> UP
    expect_out(K_DIR, 1, "t1_dir_up");
    expect_out(K_TGT, 7, "t1_target7");
    expect_out(K_STOP, 0, "t1_no_stop_at0");
    car_stopped = 1'b0;
    car_floor   = 3'd3;
    tick();                                   // c4
    expect_out(K_DIR, 1, "t1_dir_up_mid");
    car_floor = 3'd7;
    tick();                                   // c5: at top, not yet stopped
    expect_out(K_STOP, 1, "t1_stop_at7");
    expect_out(K_DIR, 0, "t1_no_up_at_top");
    car_stopped = 1'b1;
    tick();                                   // c6: UP -> SERVE
    expect_out(K_OPEN, 1, "t1_open");
    expect_out(K_STOP, 1, "t1_stop_serve");
    expect_out(K_DIR, 0, "t1_dir_serve");
    tick();                                   // c7: call cleared
    expect_out(K_LIN, 0, "t1_lamp_in7_cleared");
    door_done = 1'b1;
    tick();                                   // c8: SERVE -> IDLE
    door_done = 1'b0;
    expect_out(K_OPEN, 0, "t1_closed");
    expect_out(K_DIR, 0, "t1_idle");

    // Test 2: hall call at the car's own floor, then a call to the bottom.
    btn_down_out = 8'h80;
    tick();                                   // c9
    btn_down_out = '0;
    expect_out(K_LDN, 32'h80, "t2_lamp_down7");
    tick();                                   // c10: IDLE -> SERVE
    expect_out(K_OPEN, 1, "t2_serve_in_place");
    expect_out(K_DIR, 0, "t2_no_motion");
    tick();                                   // c11
    expect_out(K_LDN, 0, "t2_lamp_down7_cleared");
    door_done = 1'b1;
    tick();                                   // c12: -> IDLE
    door_done  = 1'b0;
    btn_up_out = 8'h01;
    expect_out(K_OPEN, 0, "t2_closed");
    tick();                                   // c13
    btn_up_out = '0;
    expect_out(K_LUP, 32'h01, "t2_lamp_up0");
    tick();                                   // c14: IDLE -> DOWN
    expect_out(K_DIR, 2, "t2_dir_down");
    expect_out(K_TGT, 0, "t2_target0");
    car_stopped = 1'b0;
    car_floor   = 3'd0;
    tick();                                   // c15: at bottom
    expect_out(K_DIR, 0, "t2_no_down_at_bottom");
    expect_out(K_STOP, 1, "t2_stop_at0");
    car_stopped = 1'b1;
    tick();                                   // c16: -> SERVE
    expect_out(K_OPEN, 1, "t2_open_at0");
    tick();                                   // c17
    expect_out(K_LUP, 0, "t2_lamp_up0_cleared");
    door_done = 1'b1;
    tick();                                   // c18: -> IDLE
    door_done = 1'b0;
    expect_out(K_DIR, 0, "t2_idle");

    // Test 3: opposite-direction hall call is passed, served after reversal.
    btn_in = 8'h20;
    tick();                                   // c19
    btn_in = '0;
    tick();                                   // c20: IDLE -> UP
    expect_out(K_DIR, 1, "t3_dir_up");
    expect_out(K_TGT, 5, "t3_target5");
    car_stopped  = 1'b0;
    car_floor    = 3'd1;
    btn_down_out = 8'h08;
    tick();                                   // c21
    btn_down_out = '0;
    car_floor    = 3'd3;
    tick();                                   // c22: passing floor 3
    expect_out(K_STOP, 0, "t3_pass_floor3");
    expect_out(K_DIR, 1, "t3_still_up");
    expect_out(K_TGT, 5, "t3_target_still5");
    car_floor = 3'd5;
    tick();                                   // c23
    expect_out(K_STOP, 1, "t3_stop_at5");
    car_stopped = 1'b1;
    tick();                                   // c24: -> SERVE
    tick();                                   // c25
    expect_out(K_LIN, 0, "t3_lamp_in5_cleared");
    expect_out(K_LDN, 32'h08, "t3_lamp_down3_kept");
    door_done = 1'b1;
    tick();                                   // c26: reverse to DOWN
    door_done   = 1'b0;
    expect_out(K_DIR, 2, "t3_reverse_down");
    expect_out(K_TGT, 3, "t3_target3");
    car_stopped = 1'b0;
    car_floor   = 3'd3;
    tick();                                   // c27
    expect_out(K_STOP, 1, "t3_stop_at3");
    car_stopped = 1'b1;
    tick();                                   // c28: -> SERVE
    tick();                                   // c29
    expect_out(K_LDN, 0, "t3_lamp_down3_cleared");
    door_done = 1'b1;
    tick();                                   // c30: -> IDLE
    door_done = 1'b0;

    // Test 4: same-direction hall call en route, then continue up.
    car_floor  = 3'd0;
    btn_in     = 8'h40;
    btn_up_out = 8'h04;
    tick();                                   // c31
    btn_in     = '0;
    btn_up_out = '0;
    tick();                                   // c32: IDLE -> UP
    expect_out(K_TGT, 2, "t4_target2");
    car_stopped = 1'b0;
    car_floor   = 3'd2;
    tick();                                   // c33
    expect_out(K_STOP, 1, "t4_stop_at2");
    car_stopped = 1'b1;
    tick();                                   // c34: -> SERVE
    tick();                                   // c35
    expect_out(K_LUP, 0, "t4_lamp_up2_cleared");
    expect_out(K_LIN, 32'h40, "t4_lamp_in6_kept");
    door_done = 1'b1;
    tick();                                   // c36: continue UP
    door_done = 1'b0;
    expect_out(K_DIR, 1, "t4_continue_up");
    expect_out(K_TGT, 6, "t4_target6");
    car_stopped = 1'b0;
    car_floor   = 3'd6;
    tick();                                   // c37
    car_stopped = 1'b1;
    tick();                                   // c38: -> SERVE
    tick();                                   // c39
    expect_out(K_LIN, 0, "t4_lamp_in6_cleared");
    door_done = 1'b1;
    tick();                                   // c40: -> IDLE
    door_done = 1'b0;

    // Test 5: impossible hall calls ignored; held cab button during SERVE.
    btn_up_out   = 8'h80;
    btn_down_out = 8'h01;
    tick();                                   // c41
    expect_out(K_LUP, 0, "t5_no_up_at_top");
    expect_out(K_LDN, 0, "t5_no_down_at_bottom");
    tick();                                   // c42
    btn_up_out   = '0;
    btn_down_out = '0;
    expect_out(K_DIR, 0, "t5_stays_idle");
    btn_in = 8'h40;
    tick();                                   // c43
    expect_out(K_LIN, 32'h40, "t5_lamp_in6_set");
    tick();                                   // c44: -> SERVE
    expect_out(K_OPEN, 1, "t5_serve");
    tick();                                   // c45
    expect_out(K_LIN, 0, "t5_clear_beats_press_a");
    tick();                                   // c46
    expect_out(K_LIN, 0, "t5_clear_beats_press_b");
    door_done = 1'b1;
    tick();                                   // c47: -> IDLE, still clearing
    expect_out(K_LIN, 0, "t5_clear_on_exit");
    btn_in    = '0;
    door_done = 1'b0;
    tick();                                   // c48

    // Test 6: asynchronous reset while moving with calls pending.
    car_floor    = 3'd0;
    btn_in       = 8'h08;
    btn_up_out   = 8'h10;
    btn_down_out = 8'h20;
    tick();                                   // c49
    btn_in       = '0;
    btn_up_out   = '0;
    btn_down_out = '0;
    tick();                                   // c50: IDLE -> UP
    expect_out(K_DIR, 1, "t6_dir_up");
    expect_out(K_LIN, 32'h08, "t6_lamp_in3");
    expect_out(K_LUP, 32'h10, "t6_lamp_up4");
    expect_out(K_LDN, 32'h20, "t6_lamp_down5");
    @(posedge clk); #2;                       // c51, assert reset between edges
    reset = 1'b0;
    expect_reset_state("t6_async");
    @(negedge clk); #1;
    reset = 1'b1;
    tick();                                   // c52
    expect_out(K_DIR, 0, "t6_idle_after_release");
    expect_out(K_LIN, 0, "t6_calls_dropped");

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb.size());
      total = total + sb.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Collective-control scheduler sitting between the floor/cab push-buttons and the `elevator` motion/door controller.
- Latches cab and hall calls and drives the call lamps.
- Runs a SCAN (sweep) direction policy and tells the car which way to move, where to stop, and when to open.
- Clears each call when the car serves it.

Parameters:
BUTTONS_WIDTH, 8, number of floors (one button bit per floor, floor 0 = bit 0)
FLOOR_BITS, 3, width of floor index; must satisfy 2^FLOOR_BITS >= BUTTONS_WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
btn_in  input  BUTTONS_WIDTH  cab floor buttons, level, OR-latched
btn_up_out  input  BUTTONS_WIDTH  hall up-call buttons
btn_down_out  input  BUTTONS_WIDTH  hall down-call buttons
car_floor  input  FLOOR_BITS  current car floor from position sensors
car_stopped  input  1  car halted and levelled at car_floor
door_done  input  1  1-cycle pulse: door cycle finished, door closed
dir  output  2  requested motion: 00 idle, 01 up, 10 down (11 never driven)
stop_req  output  1  car must stop at car_floor
open_req  output  1  high while in SERVE: door controller opens/holds door
target_floor  output  FLOOR_BITS  nearest pending floor in current sweep direction
lamp_in, lamp_up, lamp_down  output  BUTTONS_WIDTH each  pending-call registers (drive button lamps)

Behaviour:
- Reset (async, reset=0): all lamps 0, state IDLE, dir=00, stop_req=0, open_req=0, target_floor=0, sweep memory=UP. Reset mid-sweep drops every pending call.
- Latching: pend_x <= pend_x | btn_x every cycle. Lamp visible 1 cycle after press.
  - btn_up_out[BUTTONS_WIDTH-1] and btn_down_out[0] are never latched.
- Definitions: above = any pending bit (any of the 3 vectors) at floor > car_floor; below = same for floor < car_floor.
- States IDLE, UP, DOWN, SERVE. All outputs are registered, so each output reflects the state entered on that edge.
- IDLE (dir=00):
  - Any pending at car_floor and car_stopped -> SERVE.
  - Else above -> UP.
  - Else below -> DOWN.
  - Ties are resolved in that order.
- UP (dir=01):
  - stop_req = pend_in[f] | pend_up[f] | (pend_down[f] & !above).
  - car_stopped & stop_req -> SERVE with sweep=UP.
  - !above & no call at f: below -> DOWN, else -> IDLE.
- DOWN (dir=10): mirror of UP, with pend_down/pend_up swapped and below/above swapped.
- SERVE (dir=00, open_req=1):
  - Each cycle clears pend_in[f] and the sweep-direction hall bit at f.
  - Also clears the opposite hall bit at f if no calls exist beyond f in the sweep direction (reversal).
  - Clear beats a simultaneous press of the same bit.
  - Exits on door_done: continue in sweep direction if calls exist beyond; else reverse if calls exist the other way; else IDLE.
- target_floor: in UP, lowest pending floor > f; in DOWN, highest pending floor < f; in IDLE/SERVE, car_floor.
- door_done outside SERVE is ignored. A car_floor change while in SERVE is a controller fault and is not handled.
- Top/bottom: the car never gets dir=01 at floor BUTTONS_WIDTH-1, nor dir=10 at floor 0.

Test Plan:
1. Reset low 10 ns then high; car at 0 stopped; pulse btn_in[7] -> lamp_in[7]=1 next edge, dir=01, target_floor=7. Set car_floor=7 and car_stopped -> stop_req=1, SERVE, open_req=1, lamp_in[7]=0. Pulse door_done -> IDLE, dir=00.
2. Car idle at 7; pulse btn_down_out[7] -> SERVE immediately without moving, lamp_down[7] cleared. Then btn_up_out[0] -> dir=10, target_floor=0. Arrival at 0 -> serve, return to IDLE.
3. Car moving UP from 0 with btn_in[5] pending; btn_down_out[3] pressed -> no stop at 3 (stop_req=0 at car_floor=3). Serve 5, reverse to DOWN, then stop at 3 and clear lamp_down[3].
4. Car going UP past 2 with btn_up_out[2] and btn_in[6] pending -> stops at 2, lamp_up[2] cleared, continues UP after door_done, target_floor=6.
5. Press btn_up_out[7] and btn_down_out[0] -> lamps stay 0, dir stays 00. Hold btn_in[car_floor] throughout SERVE -> lamp stays 0.
6. Reset asserted while dir=01 with 3 calls pending -> all lamps, dir, stop_req and open_req go 0 asynchronously, before the next clock edge. On release the scheduler is in IDLE.
